// File: rtl/ysyx_25030085_lsu_pkg.sv
// Shared definitions for the load/store unit: memory-op codes, response error codes, FSM states.
// Latency: n/a (constants only).
// Backpressure: n/a.
package ysyx_25030085_lsu_pkg;

  // Memory-op encodings presented on req_op
  localparam logic [2:0] MEM_B  = 3'b000;
  localparam logic [2:0] MEM_H  = 3'b001;
  localparam logic [2:0] MEM_W  = 3'b010;
  localparam logic [2:0] MEM_BU = 3'b100;
  localparam logic [2:0] MEM_HU = 3'b101;

  // rsp_err encodings
  localparam logic [1:0] ERR_OK  = 2'b00;
  localparam logic [1:0] ERR_MIS = 2'b01;
  localparam logic [1:0] ERR_TO  = 2'b10;
  localparam logic [1:0] ERR_ILL = 2'b11;

  // FSM states
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

endpackage

// File: rtl/ysyx_25030085_lsu_align.sv
// Alignment/lane helper: legality and alignment flags, store lane replication and byte mask, load extraction.
// Latency: purely combinational.
// Backpressure: none.
// Ports: chk_* describe the access being accepted; ld_* describe the registered load whose word is returning.
module ysyx_25030085_lsu_align
  import ysyx_25030085_lsu_pkg::*;
(
  input  logic [2:0]  chk_op,
  input  logic [1:0]  chk_off,
  input  logic [31:0] st_rs2,
  output logic        illegal,
  output logic        misaligned,
  output logic [3:0]  st_mask,
  output logic [31:0] st_wdata,
  input  logic [2:0]  ld_op,
  input  logic [1:0]  ld_off,
  input  logic [31:0] ld_rdata,
  output logic [31:0] ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    illegal    = 1'b1;
    misaligned = 1'b0;
    st_mask    = 4'b0000;
    st_wdata   = 32'h0;
    case (chk_op)
      MEM_B, MEM_BU: begin
        illegal  = 1'b0;
        st_mask  = 4'b0001 << chk_off;
        st_wdata = {4{st_rs2[7:0]}};
      end
      MEM_H, MEM_HU: begin
        illegal    = 1'b0;
        misaligned = chk_off[0];
        st_mask    = 4'b0011 << chk_off;
        st_wdata   = {2{st_rs2[15:0]}};
      end
      MEM_W: begin
        illegal    = 1'b0;
        misaligned = |chk_off;
        st_mask    = 4'b1111;
        st_wdata   = st_rs2;
      end
      default: ;
    endcase
  end

  // Halfword lane is picked by off[1] only; off[0] is guaranteed 0 for halves that reach memory.
  always_comb begin
    ld_byte = ld_rdata[8*ld_off +: 8];
    ld_half = ld_rdata[16*ld_off[1] +: 16];
    case (ld_op)
      MEM_B:   ld_data = {{24{ld_byte[7]}}, ld_byte};
      MEM_BU:  ld_data = {24'h0, ld_byte};
      MEM_H:   ld_data = {{16{ld_half[15]}}, ld_half};
      MEM_HU:  ld_data = {16'h0, ld_half};
      default: ld_data = ld_rdata;
    endcase
  end

endmodule

// File: rtl/ysyx_25030085_lsu.sv
// Load/store unit: accepts one access from execute, issues a word-aligned byte-masked memory request, returns result/error.
// Latency: >=2 cycles accept->rsp_valid with an immediate memory; errors 1 cycle; timeout TIMEOUT cycles in WAIT.
// Backpressure: single outstanding; req_ready only in IDLE; request fields held stable while mem_req_ready is low.
module ysyx_25030085_lsu
  import ysyx_25030085_lsu_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_read,
  input  logic        req_write,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic [1:0]  rsp_err
);

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [1:0]    state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    op_q, op_d;
  logic [31:0]   addr_q, addr_d;
  logic          we_q, we_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    wmask_q, wmask_d;
  logic [31:0]   rsp_data_q, rsp_data_d;
  logic [1:0]    rsp_err_q, rsp_err_d;

  logic          illegal, misaligned;
  logic [3:0]    st_mask;
  logic [31:0]   st_wdata, ld_data;
  logic          accept, is_store;

  ysyx_25030085_lsu_align u_align (
    .chk_op     (req_op),
    .chk_off    (req_addr[1:0]),
    .st_rs2     (req_wdata),
    .illegal    (illegal),
    .misaligned (misaligned),
    .st_mask    (st_mask),
    .st_wdata   (st_wdata),
    .ld_op      (op_q),
    .ld_off     (addr_q[1:0]),
    .ld_rdata   (mem_rdata),
    .ld_data    (ld_data)
  );

  // An access with neither read nor write is not a transaction and is never accepted.
  assign req_ready = (state_q == ST_IDLE);
  assign accept    = req_valid & req_ready & (req_read | req_write);
  assign is_store  = req_write & ~req_read;

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    op_d       = op_q;
    addr_d     = addr_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    wmask_d    = wmask_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op_d    = req_op;
          addr_d  = req_addr;
          we_d    = is_store;
          wdata_d = is_store ? st_wdata : 32'h0;
          wmask_d = is_store ? st_mask  : 4'b0000;
          if (illegal) begin
            state_d    = ST_RESP;
            rsp_err_d  = ERR_ILL;
            rsp_data_d = 32'h0;
          end else if (misaligned) begin
            state_d    = ST_RESP;
            rsp_err_d  = ERR_MIS;
            rsp_data_d = 32'h0;
          end else begin
            state_d = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        if (mem_req_ready) begin
          timer_d = '0;
          // A memory that answers in the handshake cycle skips WAIT entirely.
          if (mem_rsp_valid) begin
            state_d    = ST_RESP;
            rsp_err_d  = ERR_OK;
            rsp_data_d = we_q ? 32'h0 : ld_data;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (mem_rsp_valid) begin
          state_d    = ST_RESP;
          rsp_err_d  = ERR_OK;
          rsp_data_d = we_q ? 32'h0 : ld_data;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          state_d    = ST_RESP;
          rsp_err_d  = ERR_TO;
          rsp_data_d = 32'h0;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      timer_q    <= '0;
      op_q       <= 3'b000;
      addr_q     <= 32'h0;
      we_q       <= 1'b0;
      wdata_q    <= 32'h0;
      wmask_q    <= 4'b0000;
      rsp_data_q <= 32'h0;
      rsp_err_q  <= ERR_OK;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      wmask_q    <= wmask_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  assign mem_req_valid = (state_q == ST_REQ);
  assign mem_we        = we_q;
  assign mem_addr      = {addr_q[31:2], 2'b00};
  assign mem_wdata     = wdata_q;
  assign mem_wmask     = wmask_q;
  assign rsp_valid     = (state_q == ST_RESP);
  assign rsp_data      = rsp_data_q;
  assign rsp_err       = rsp_err_q;

endmodule

// File: tb/tb_ysyx_25030085_lsu.sv
// Testbench for the load/store unit: directed cases plus randomized accesses against a behavioural model.
// Latency: n/a.
// Backpressure: the bench plays the memory, stalling mem_req_ready and delaying or withholding responses.
module tb_ysyx_25030085_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_read, req_write;
  logic [2:0]  req_op;
  logic [31:0] req_addr, req_wdata;
  logic        mem_req_valid, mem_req_ready, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_rsp_valid;
  logic [31:0] mem_rdata;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_err;

  int checks = 0;
  int errors = 0;

  ysyx_25030085_lsu #(.TIMEOUT(16)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_read      (req_read),
    .req_write     (req_write),
    .req_op        (req_op),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_wmask     (mem_wmask),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rdata     (mem_rdata),
    .rsp_valid     (rsp_valid),
    .rsp_data      (rsp_data),
    .rsp_err       (rsp_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: access size in bytes, signedness, byte-lane arithmetic.
  function automatic void model(input logic rd, input logic wr, input logic [2:0] op,
                                input logic [31:0] addr, input logic [31:0] rs2,
                                input logic [31:0] rdata, input int rsp_dly,
                                output logic [1:0] err, output logic [31:0] data,
                                output logic [3:0] mask, output logic [31:0] wd);
    int size, off;
    bit sgn, legal, store;
    longint v, lim;
    legal = 1; size = 1; sgn = 0;
    case (op)
      3'd0: begin size = 1; sgn = 1; end
      3'd1: begin size = 2; sgn = 1; end
      3'd2: begin size = 4; sgn = 0; end
      3'd4: begin size = 1; sgn = 0; end
      3'd5: begin size = 2; sgn = 0; end
      default: legal = 0;
    endcase
    store = wr && !rd;
    off = int'(addr % 4);
    if (!legal)               err = 2'd3;
    else if (off % size != 0) err = 2'd1;
    else if (rsp_dly < 0)     err = 2'd2;
    else                      err = 2'd0;
    mask = 4'b0000;
    wd   = 32'h0;
    if (store) begin
      for (int i = 0; i < 4; i++) begin
        wd[8*i +: 8] = rs2[8*(i % size) +: 8];
        if (i >= off && i < off + size) mask[i] = 1'b1;
      end
    end
    data = 32'h0;
    if (err == 2'd0 && !store) begin
      lim = 64'd1 << (8 * size);
      v = (longint'(rdata) >> (8 * off)) % lim;
      if (sgn && v >= lim / 2) v = v - lim;
      data = 32'(v);
    end
  endfunction

  task automatic check_fields(input logic [31:0] e_addr, input logic e_we,
                              input logic [3:0] e_mask, input logic [31:0] e_wd);
    check("mem_req_valid", mem_req_valid, 1);
    check("req_ready_busy", req_ready, 0);
    check("mem_addr", mem_addr, e_addr);
    check("mem_we", mem_we, e_we);
    check("mem_wmask", mem_wmask, e_mask);
    if (e_we) check("mem_wdata", mem_wdata, e_wd);
  endtask

  // One full access. rdy_dly = cycles mem_req_ready stays low; rsp_dly = 0 same-cycle,
  // n>0 response after n WAIT cycles, <0 never (timeout).
  task automatic access(input logic rd, input logic wr, input logic [2:0] op,
                        input logic [31:0] addr, input logic [31:0] rs2, input logic [31:0] rdata,
                        input int rdy_dly, input int rsp_dly);
    logic [1:0]  e_err;
    logic [31:0] e_data, e_wd, e_addr;
    logic [3:0]  e_mask;
    logic        e_we;
    int n;
    model(rd, wr, op, addr, rs2, rdata, rsp_dly, e_err, e_data, e_mask, e_wd);
    e_we   = wr && !rd;
    e_addr = addr - (addr % 4);
    @(negedge clk);
    check("req_ready_idle", req_ready, 1);
    req_valid = 1; req_read = rd; req_write = wr; req_op = op; req_addr = addr; req_wdata = rs2;
    @(negedge clk);
    req_valid = 0; req_read = 0; req_write = 0; req_wdata = $urandom;
    if (e_err == 2'd1 || e_err == 2'd3) begin
      check("err_rsp_valid", rsp_valid, 1);
      check("err_code", rsp_err, e_err);
      check("err_data", rsp_data, 0);
      check("err_no_mem", mem_req_valid, 0);
      @(negedge clk);
      check("err_pulse", rsp_valid, 0);
      check("err_no_mem2", mem_req_valid, 0);
    end else begin
      for (int i = 0; i < rdy_dly; i++) begin
        check_fields(e_addr, e_we, e_mask, e_wd);
        @(negedge clk);
      end
      check_fields(e_addr, e_we, e_mask, e_wd);
      mem_req_ready = 1;
      if (rsp_dly == 0) begin mem_rsp_valid = 1; mem_rdata = rdata; end
      @(negedge clk);
      mem_req_ready = 0; mem_rsp_valid = 0; mem_rdata = $urandom;
      n = 0;
      while (rsp_valid !== 1'b1 && n < 40) begin
        if (rsp_dly > 0 && n + 1 == rsp_dly) begin mem_rsp_valid = 1; mem_rdata = rdata; end
        else mem_rsp_valid = 0;
        @(negedge clk);
        n++;
      end
      mem_rsp_valid = 0;
      check("wait_cycles", n, (rsp_dly < 0) ? 16 : rsp_dly);
      check("rsp_valid", rsp_valid, 1);
      check("rsp_err", rsp_err, e_err);
      check("rsp_data", rsp_data, e_data);
      check("no_mem_in_resp", mem_req_valid, 0);
      @(negedge clk);
      check("rsp_pulse", rsp_valid, 0);
      check("rsp_data_hold", rsp_data, e_data);
    end
  endtask

  initial begin
    logic [2:0] op_tab [8];
    logic [2:0] rop;
    logic       rrd, rwr;
    int         k;
    op_tab = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd2, 3'd3, 3'd6};
    rst_n = 0; req_valid = 0; req_read = 0; req_write = 0; req_op = 0;
    req_addr = 0; req_wdata = 0; mem_req_ready = 0; mem_rsp_valid = 0; mem_rdata = 0;
    #12;
    check("rst_req_ready", req_ready, 1);
    check("rst_mem_req_valid", mem_req_valid, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_mem_wmask", mem_wmask, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_rsp_err", rsp_err, 0);
    @(negedge clk);
    rst_n = 1;

    // Directed cases
    access(0, 1, 3'd0, 32'h8000_0003, 32'h0000_00AB, 32'h0, 0, 1);   // sb, lane 3
    access(1, 0, 3'd0, 32'h8000_0001, 32'h0, 32'h1234_80FF, 0, 1);   // lb
    access(1, 0, 3'd4, 32'h8000_0001, 32'h0, 32'h1234_80FF, 0, 1);   // lbu
    access(1, 0, 3'd1, 32'h8000_0002, 32'h0, 32'h8001_0000, 0, 0);   // lh, same-cycle response
    access(1, 0, 3'd2, 32'h8000_0002, 32'h0, 32'h0, 0, 1);           // lw misaligned
    access(0, 1, 3'd1, 32'h8000_0006, 32'hCAFE_BEEF, 32'h0, 5, 2);   // sh, ready stalled 5
    access(1, 0, 3'd2, 32'h8000_0010, 32'h0, 32'hDEAD_BEEF, 0, -1);  // timeout
    access(1, 1, 3'd2, 32'h8000_0014, 32'h5555_AAAA, 32'h0BAD_F00D, 1, 3); // read+write is a load
    access(1, 0, 3'd3, 32'h8000_0000, 32'h0, 32'h0, 0, 1);           // illegal op

    // req_valid without read or write is not accepted
    @(negedge clk);
    req_valid = 1; req_read = 0; req_write = 0; req_op = 3'd2; req_addr = 32'h8000_0020;
    repeat (2) @(negedge clk);
    check("noop_req_ready", req_ready, 1);
    check("noop_mem_req_valid", mem_req_valid, 0);
    check("noop_rsp_valid", rsp_valid, 0);
    req_valid = 0;

    // Reset in WAIT abandons the access; a late response is ignored
    @(negedge clk);
    req_valid = 1; req_read = 1; req_op = 3'd2; req_addr = 32'h8000_0030;
    @(negedge clk);
    req_valid = 0; req_read = 0; mem_req_ready = 1;
    @(negedge clk);
    mem_req_ready = 0;
    repeat (3) @(negedge clk);
    rst_n = 0;
    #1;
    check("midrst_req_ready", req_ready, 1);
    check("midrst_mem_req_valid", mem_req_valid, 0);
    check("midrst_mem_addr", mem_addr, 0);
    check("midrst_rsp_valid", rsp_valid, 0);
    check("midrst_rsp_data", rsp_data, 0);
    @(negedge clk);
    rst_n = 1; mem_rsp_valid = 1; mem_rdata = 32'h1111_2222;
    @(negedge clk);
    mem_rsp_valid = 0;
    for (int i = 0; i < 3; i++) begin
      check("late_rsp_ignored", rsp_valid, 0);
      check("late_rsp_no_mem", mem_req_valid, 0);
      @(negedge clk);
    end

    // Randomized accesses
    for (int it = 0; it < 60; it++) begin
      rop = op_tab[$urandom_range(0, 7)];
      k = $urandom_range(0, 2);
      rrd = (k != 1);
      rwr = (k != 0);
      if (rwr && !rrd && (rop == 3'd4 || rop == 3'd5)) rop = 3'd0;
      access(rrd, rwr, rop, 32'h8000_0000 | 32'($urandom_range(0, 255)), $urandom, $urandom,
             $urandom_range(0, 3), $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
